posit_weight_serializer: RTL

- Transmit end of the bit-serial posit weight interface consumed by the FP×posit multiplier.
- Accepts parallel posit weights (es=0, up to 8 bits) over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Streams each weight MSB-first, one bit per cycle, on w_out/valid_out, so a frame is sign, then regime, then mantissa bits.
- Forwards the precision configuration to the receiver via set_out/precision_out.

---
 rtl/posit_weight_serializer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/posit_weight_serializer.sv
// posit_weight_serializer
//   Transmit side of the bit-serial posit weight link. Parallel posit weights
//   (es=0, up to POSIT_WIDTH bits, right-aligned) enter through a valid/ready
//   handshake into a 2-entry FIFO and leave MSB-first, one bit per cycle.
//   Frames are back-to-back when the next word is already buffered.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   set, precision      config strobe and requested frame width (clamped 2..POSIT_WIDTH)
//   in_word, in_valid   parallel posit input; in_ready = FIFO not full
//   w_out, valid_out    serial bit and its qualifier
//   frame_start/last    first (sign) and last bit of a frame
//   set_out             one-cycle pulse carrying an accepted config on precision_out
//   precision_out       latched frame width
//   cfg_err             one-cycle pulse when set arrives while busy
//   busy                shifting or FIFO non-empty
//   words_sent          completed-frame counter (wraps)
module posit_weight_serializer #(
  parameter int unsigned POSIT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set,
  input  logic [3:0]             precision,
  input  logic [POSIT_WIDTH-1:0] in_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   w_out,
  output logic                   valid_out,
  output logic                   frame_start,
  output logic                   frame_last,
  output logic                   set_out,
  output logic [3:0]             precision_out,
  output logic                   cfg_err,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   words_sent
);

  localparam int unsigned PREC_W   = 4;
  localparam int unsigned DEPTH    = 2;
  localparam logic [PREC_W-1:0] PREC_MIN = PREC_W'(2);
  localparam logic [PREC_W-1:0] PREC_MAX = PREC_W'(POSIT_WIDTH);
  localparam logic [PREC_W-1:0] PREC_RST = PREC_W'((POSIT_WIDTH < 8) ? POSIT_WIDTH : 8);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state_q, state_n;
  logic [POSIT_WIDTH-1:0]   fifo_q [DEPTH];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               count_q, count_n;
  logic [POSIT_WIDTH-1:0]   shreg_q, shreg_n;
  logic [PREC_W-1:0]        bit_idx_q, bit_idx_n;
  logic [PREC_W-1:0]        prec_n, prec_req;
  logic                     w_n, valid_n, fs_n, fl_n, set_out_n, cfg_err_n, busy_n;
  logic [CNT_WIDTH-1:0]     words_n;
  logic                     push, pop;
  logic [PREC_W-1:0]        bit_sel;
  logic [POSIT_WIDTH-1:0]   bit_mask;
  logic                     frame_end;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot
  assign in_ready = (count_q < 2'(DEPTH));
  assign push     = in_valid && in_ready;

  // Current bit of the frame: word[prec-1-bit_idx]
  assign bit_sel   = precision_out - PREC_W'(1) - bit_idx_q;
  assign bit_mask  = POSIT_WIDTH'(1) << bit_sel;
  assign frame_end = (bit_idx_q == precision_out - PREC_W'(1));

  // Requested precision clamped into the legal range
  always_comb begin
    prec_req = precision;
    if (precision < PREC_MIN)      prec_req = PREC_MIN;
    else if (precision > PREC_MAX) prec_req = PREC_MAX;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    bit_idx_n = bit_idx_q;
    prec_n    = precision_out;
    w_n       = 1'b0;
    valid_n   = 1'b0;
    fs_n      = 1'b0;
    fl_n      = 1'b0;
    set_out_n = 1'b0;
    cfg_err_n = 1'b0;
    words_n   = words_sent;
    pop       = 1'b0;

    // Config is only taken when nothing is in flight, so a frame never changes width
    if (set) begin
      if (busy) begin
        cfg_err_n = 1'b1;
      end else begin
        prec_n    = prec_req;
        set_out_n = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop       = 1'b1;
          shreg_n   = fifo_q[rd_ptr_q];
          bit_idx_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        valid_n = 1'b1;
        w_n     = |(shreg_q & bit_mask);
        fs_n    = (bit_idx_q == '0);
        if (frame_end) begin
          fl_n    = 1'b1;
          words_n = words_sent + CNT_WIDTH'(1);
          if (count_q != 2'd0) begin
            // Chain the next buffered word with no gap
            pop       = 1'b1;
            shreg_n   = fifo_q[rd_ptr_q];
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_idx_n = bit_idx_q + PREC_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    count_n = count_q + 2'(push) - 2'(pop);
    busy_n  = (state_n == SHIFT) || (count_n != 2'd0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      precision_out <= PREC_RST;
      w_out         <= 1'b0;
      valid_out     <= 1'b0;
      frame_start   <= 1'b0;
      frame_last    <= 1'b0;
      set_out       <= 1'b0;
      cfg_err       <= 1'b0;
      busy          <= 1'b0;
      words_sent    <= '0;
    end else begin
      state_q       <= state_n;
      wr_ptr_q      <= wr_ptr_q ^ push;
      rd_ptr_q      <= rd_ptr_q ^ pop;
      count_q       <= count_n;
      shreg_q       <= shreg_n;
      bit_idx_q     <= bit_idx_n;
      precision_out <= prec_n;
      w_out         <= w_n;
      valid_out     <= valid_n;
      frame_start   <= fs_n;
      frame_last    <= fl_n;
      set_out       <= set_out_n;
      cfg_err       <= cfg_err_n;
      busy          <= busy_n;
      words_sent    <= words_n;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_word;
  end

endmodule
